muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
//------------------------------------------------------------------------------
// muldiv_seq -- sequential RV32M multiply/divide unit (shift-add / restoring).
// Optional macro MULDIV_SEQ_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip RUN/FIX and complete one cycle after accept.
// Revision: 1.0 -- initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Operand decode at accept: MUL and the unsigned ops work on raw bits.
  logic             w_a_signed, w_b_signed, w_sa, w_sb, w_dz;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_sa       = w_a_signed & a[WIDTH-1];
  assign w_sb       = w_b_signed & b[WIDTH-1];
  assign w_mag_a    = w_sa ? -a : a;
  assign w_mag_b    = w_sb ? -b : b;
  assign w_dz       = (b == '0);

`ifdef MULDIV_SEQ_EARLY_OUT_EN
  logic             w_ovf;
  logic [WIDTH-1:0] w_early_res;
  assign w_ovf       = op[2] & ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
  assign w_early_res = w_dz ? (op[1] ? a : '1) : (op[1] ? '0 : a);
`endif

  // Single shared adder: multiply adds the multiplicand into the high half,
  // divide subtracts the divisor from the shifted partial remainder.
  logic [WIDTH+1:0] w_add_x, w_add_y, w_sum;
  logic             w_add_cin, w_ge;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;

  always_comb begin
    w_add_x   = '0;
    w_add_y   = '0;
    w_add_cin = 1'b0;
    if (op_q[2]) begin
      w_add_x   = {1'b0, hi_q, lo_q[WIDTH-1]};
      w_add_y   = ~{2'b00, opb_q};
      w_add_cin = 1'b1;
    end else begin
      w_add_x = {2'b00, hi_q};
      w_add_y = lo_q[0] ? {2'b00, opb_q} : '0;
    end
  end

  assign w_sum = w_add_x + w_add_y + {{(WIDTH+1){1'b0}}, w_add_cin};
  assign w_ge  = ~w_sum[WIDTH+1];

  always_comb begin
    if (op_q[2]) begin
      w_step_hi = w_ge ? w_sum[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      w_step_lo = {lo_q[WIDTH-2:0], w_ge};
    end else begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection; zero divisor forces an all-ones quotient.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem, w_fix_res;

  assign w_prod = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign w_quot = dz_q ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
  assign w_rem  = sa_q ? -hi_q : hi_q;

  always_comb begin
    if (op_q[2])
      w_fix_res = op_q[1] ? w_rem : w_quot;
    else
      w_fix_res = (op_q[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          sa_d    = w_sa;
          sb_d    = w_sb;
          dz_d    = w_dz;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = op[2] ? w_mag_a : w_mag_b;
          opb_d   = op[2] ? w_mag_b : w_mag_a;
          state_d = RUN;
`ifdef MULDIV_SEQ_EARLY_OUT_EN
          if (op[2] && (w_dz || w_ovf)) begin
            res_d   = w_early_res;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          hi_d  = w_step_hi;
          lo_d  = w_step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == C_LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          res_d   = w_fix_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
//------------------------------------------------------------------------------
// tb_muldiv_seq -- scoreboard bench for muldiv_seq against an arithmetic model.
// Revision: 1.0 -- initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq;

  localparam int W = 32;
  localparam logic [W-1:0] C_MIN = 32'h8000_0000;
`ifdef MULDIV_SEQ_EARLY_OUT_EN
  localparam bit C_EARLY = 1'b1;
`else
  localparam bit C_EARLY = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, res;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    logic [2:0]   op;
  } exp_t;

  exp_t         sbq[$];
  int           n_checks = 0, n_errors = 0, cyc = 0, bp_mode = 0;
  bit           mon_off = 1'b0, seen = 1'b0;
  logic [W-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic plus the RV32M special cases.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    logic [63:0]     p;
    bit              ovf = (x == C_MIN) && (y == '1);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin if (y == 0) return '1; if (ovf) return x; p = sx / sy; return p[31:0]; end
      3'd5: return (y == 0) ? '1 : x / y;
      3'd6: begin if (y == 0) return x; if (ovf) return '0; p = sx % sy; return p[31:0]; end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit eo = o[2] && ((y == 0) || (!o[0] && x == C_MIN && y == '1));
    return (C_EARLY && eo) ? 1 : W + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return '1;
      2: return C_MIN;
      3: return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  // Offer one request and queue its expected result once accepted.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit fl = 1'b0, input bit no_edge = 1'b0);
    exp_t e;
    int   k = 0;
    if (!no_edge) begin @(posedge clk); #1; end
    in_valid = 1'b1; op = o; a = x; b = y; flush = fl;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0; flush = 1'b0;
        return;
      end
    end
    e.acc = cyc; e.res = model(o, x, y); e.lat = exp_lat(o, x, y); e.op = o;
    @(posedge clk); #1;
    sbq.push_back(e);
    in_valid = 1'b0; flush = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  // Accept without a scoreboard entry, for flows whose result is discarded.
  task automatic raw_accept(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int k = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    if (!in_ready) check("raw_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 100);
    if (!out_valid) check(name, 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || !in_ready) && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) check("drain_timeout", 0, 1);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (bp_mode == 0) out_ready = 1'b1;
  end

  // Monitor: in-flight handshake signals, latency, result stability, result value.
  always @(negedge clk) begin
    if (rst_n && !mon_off) begin
      if (sbq.size() > 0) begin
        check("busy_in_flight", 64'(busy), 1);
        check("in_ready_in_flight", 64'(in_ready), 0);
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          if (!seen) begin
            check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
            seen = 1'b1;
            held = res;
          end else begin
            check("res_stable", 64'(res), 64'(held));
          end
          if (out_ready) begin
            check($sformatf("res_op%0d", sbq[0].op), 64'(res), 64'(sbq[0].res));
            void'(sbq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_res", 64'(res), 0);
    rst_n = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, C_MIN, C_MIN);
    issue(3'd3, '1, '1);
    issue(3'd2, '1, '1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd7, 32'd5, 32'd0);
    issue(3'd4, C_MIN, '1);
    issue(3'd6, C_MIN, '1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd0);
    drain();

    // flush while idle must not block the accept in the same cycle
    issue(3'd0, 32'd3, 32'd5, 1'b1);
    drain();

    // flush on the tenth RUN cycle
    raw_accept(3'd0, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_run_out_valid", 64'(out_valid), 0);
    check("flush_run_in_ready", 64'(in_ready), 1);
    begin
      bit rose = 1'b0;
      repeat (40) begin @(negedge clk); if (out_valid) rose = 1'b1; end
      check("flush_run_never_valid", 64'(rose), 0);
    end

    // flush and out_ready together in DONE
    mon_off = 1'b1; bp_mode = 2;
    @(posedge clk); #1 out_ready = 1'b0;
    raw_accept(3'd3, 32'hFFFF_0000, 32'h1234_5678);
    wait_valid("done_flush_timeout");
    @(posedge clk); #1 flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("done_flush_out_valid", 64'(out_valid), 0);
    check("done_flush_in_ready", 64'(in_ready), 1);
    mon_off = 1'b0;

    // consumer stalls five cycles in DONE
    out_ready = 1'b0;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_valid("stall_valid_timeout");
    repeat (5) begin @(negedge clk); check("stall_in_ready", 64'(in_ready), 0); end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    bp_mode = 0;

    // asynchronous reset mid-RUN, then accept on the first edge after release
    issue(3'd0, 32'd100, 32'd200);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    sbq.delete();
    seen = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 1);
    check("arst_busy", 64'(busy), 0);
    check("arst_out_valid", 64'(out_valid), 0);
    check("arst_res", 64'(res), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 1'b0, 1'b1);
    drain();

    bp_mode = 1;
    repeat (150) issue(3'($urandom), pick(), pick());
    drain();
    bp_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
